// File: rtl/sdr_sdram_16_resp.sv
// 16-bit SDR SDRAM responder: command decode, per-bank rows, bursts, sticky errors.
// Define SDR_RESP_TIMING_CHK_EN to add per-bank tRCD/tRP checking (error code 7).
module sdr_sdram_16_resp #(
    parameter int BA_SIZE = 2,
    parameter int ROW_W   = 4,
    parameter int COL_W   = 6,
    parameter int RST_CL  = 2
`ifdef SDR_RESP_TIMING_CHK_EN
    ,
    parameter int TRCD    = 2,
    parameter int TRP     = 2
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BA_SIZE-1:0] ba,
    input  logic [12:0]        a,
    input  logic [2:0]         cmd,
    input  logic [1:0]         dqm,
    input  logic [15:0]        dq_i,
    output logic [15:0]        dq_o,
    output logic               dq_oe,
    output logic               err,
    output logic [2:0]         err_code
);
    localparam int NB    = 1 << BA_SIZE;
    localparam int AW    = BA_SIZE + ROW_W + COL_W;
    localparam int DEPTH = 1 << AW;

    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_PCH = 3'b010;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_LMR = 3'b000;

    logic [15:0]        mem [DEPTH];
    logic [NB-1:0]      open_q, open_d;
    logic [ROW_W-1:0]   row_q [NB];
    logic [ROW_W-1:0]   row_d [NB];
    logic [1:0]         cl_q, cl_d, bl_q, bl_d;
    logic               sw_q, sw_d, mset_q, mset_d;
    logic               bact_q, bact_d, bwr_q, bwr_d;
    logic [BA_SIZE-1:0] bba_q, bba_d;
    logic [ROW_W-1:0]   brow_q, brow_d;
    logic [COL_W-1:0]   bcol_q, bcol_d;
    logic [2:0]         bk_q, bk_d;
    logic [1:0]         bcode_q, bcode_d;
    logic               p1_v_q, p1_v_d, p1_oe_q, p1_oe_d;
    logic [AW-1:0]      p1_a_q, p1_a_d;
    logic               p2_v_q, p2_v_d, p2_oe_q, p2_oe_d;
    logic [AW-1:0]      p2_a_q, p2_a_d;
    logic [15:0]        dq_o_q, dq_o_d;
    logic               dq_oe_q, dq_oe_d, err_q, err_d;
    logic [2:0]         code_q, code_d;

    logic               beat_v, beat_wr, is_rdwr, pch_hit, tim_err, we;
    logic [BA_SIZE-1:0] beat_ba;
    logic [ROW_W-1:0]   beat_row;
    logic [COL_W-1:0]   beat_col, beat_c, lowmask;
    logic [2:0]         beat_k, blast;
    logic [1:0]         beat_code;
    logic [AW-1:0]      beat_addr;
    logic [7:1]         ev;
    logic               src_v, src_oe;
    logic [AW-1:0]      src_a;
    logic               unused_a;

    assign unused_a = ^a;
    assign blast    = 3'((4'd1 << bcode_q) - 4'd1);
    assign is_rdwr  = (cmd == C_RD) || (cmd == C_WR);
    assign pch_hit  = (cmd == C_PCH) && (a[10] || ba == bba_q);

    always_comb begin
        open_d    = open_q;
        row_d     = row_q;
        cl_d      = cl_q;
        bl_d      = bl_q;
        sw_d      = sw_q;
        mset_d    = mset_q;
        bact_d    = bact_q;
        bwr_d     = bwr_q;
        bba_d     = bba_q;
        brow_d    = brow_q;
        bcol_d    = bcol_q;
        bk_d      = bk_q;
        bcode_d   = bcode_q;
        ev        = '0;
        ev[7]     = tim_err;
        beat_v    = 1'b0;
        beat_wr   = bwr_q;
        beat_ba   = bba_q;
        beat_row  = brow_q;
        beat_col  = bcol_q;
        beat_k    = bk_q;
        beat_code = bcode_q;
        unique case (cmd)
            C_LMR: begin
                if (|open_q) ev[1] = 1'b1;
                if (a[2]) ev[5] = 1'b1;
                else bl_d = a[1:0];
                if (a[6:4] == 3'd2 || a[6:4] == 3'd3) cl_d = a[5:4];
                else ev[5] = 1'b1;
                sw_d   = a[9];
                mset_d = 1'b1;
            end
            C_ACT: begin
                if (open_q[ba]) ev[2] = 1'b1;
                open_d[ba] = 1'b1;
                row_d[ba]  = a[ROW_W-1:0];
            end
            C_PCH: begin
                if (a[10]) open_d = '0;
                else open_d[ba] = 1'b0;
            end
            C_REF: begin
                if (|open_q) ev[1] = 1'b1;
            end
            C_RD, C_WR: begin
                if (!mset_q) ev[4] = 1'b1;
                if (cmd == C_WR && dq_oe_q) ev[6] = 1'b1;
                bact_d = 1'b0;
                if (!open_q[ba]) begin
                    ev[3] = 1'b1;
                end else begin
                    beat_v    = 1'b1;
                    beat_wr   = (cmd == C_WR);
                    beat_ba   = ba;
                    beat_row  = row_q[ba];
                    beat_col  = a[COL_W-1:0];
                    beat_k    = 3'd0;
                    beat_code = (cmd == C_WR && sw_q) ? 2'd0 : bl_q;
                    bact_d    = (beat_code != 2'd0);
                    bwr_d     = beat_wr;
                    bba_d     = ba;
                    brow_d    = row_q[ba];
                    bcol_d    = a[COL_W-1:0];
                    bk_d      = 3'd1;
                    bcode_d   = beat_code;
                end
            end
            default: ;
        endcase
        // Continue an active burst unless a new RD/WR or a PCH of its bank cuts it.
        if (bact_q && !is_rdwr) begin
            if (pch_hit) begin
                bact_d = 1'b0;
            end else begin
                beat_v = 1'b1;
                bk_d   = bk_q + 3'd1;
                bact_d = (bk_q != blast);
            end
        end
    end

    assign lowmask   = COL_W'((8'd1 << beat_code) - 8'd1);
    assign beat_c    = (beat_col & ~lowmask)
                     | ((beat_col + COL_W'(beat_k)) & lowmask);
    assign beat_addr = {beat_ba, beat_row, beat_c};
    assign we        = beat_v && beat_wr;

    always_comb begin
        err_d  = err_q;
        code_d = code_q;
        if (!err_q && |ev) begin
            err_d = 1'b1;
            for (int i = 7; i >= 1; i--) begin
                if (ev[i]) code_d = 3'(i);
            end
        end
    end

    always_comb begin
        p1_v_d  = beat_v && !beat_wr;
        p1_oe_d = (dqm != 2'b11);
        p1_a_d  = beat_addr;
        p2_v_d  = p1_v_q;
        p2_oe_d = p1_oe_q;
        p2_a_d  = p1_a_q;
        src_v   = (cl_q == 2'd3) ? p2_v_q  : p1_v_q;
        src_oe  = (cl_q == 2'd3) ? p2_oe_q : p1_oe_q;
        src_a   = (cl_q == 2'd3) ? p2_a_q  : p1_a_q;
        dq_o_d  = src_v ? mem[src_a] : 16'h0000;
        dq_oe_d = src_v && src_oe;
    end

`ifdef SDR_RESP_TIMING_CHK_EN
    logic [3:0] rcd_q [NB];
    logic [3:0] rcd_d [NB];
    logic [3:0] trp_q [NB];
    logic [3:0] trp_d [NB];

    always_comb begin
        tim_err = 1'b0;
        for (int i = 0; i < NB; i++) begin
            rcd_d[i] = (rcd_q[i] != 4'd0) ? rcd_q[i] - 4'd1 : 4'd0;
            trp_d[i] = (trp_q[i] != 4'd0) ? trp_q[i] - 4'd1 : 4'd0;
        end
        unique case (cmd)
            C_ACT: begin
                if (trp_q[ba] != 4'd0) tim_err = 1'b1;
                rcd_d[ba] = 4'(TRCD - 1);
            end
            C_PCH: begin
                for (int i = 0; i < NB; i++) begin
                    if (a[10] || ba == BA_SIZE'(i)) trp_d[i] = 4'(TRP - 1);
                end
            end
            C_REF: begin
                for (int i = 0; i < NB; i++) begin
                    if (trp_q[i] != 4'd0) tim_err = 1'b1;
                end
            end
            C_RD, C_WR: begin
                if (rcd_q[ba] != 4'd0) tim_err = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NB; i++) begin
                rcd_q[i] <= 4'd0;
                trp_q[i] <= 4'd0;
            end
        end else begin
            rcd_q <= rcd_d;
            trp_q <= trp_d;
        end
    end
`else
    assign tim_err = 1'b0;
`endif

    // Storage is not reset; writes are blocked while reset is asserted.
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            if (!dqm[0]) mem[beat_addr][7:0]  <= dq_i[7:0];
            if (!dqm[1]) mem[beat_addr][15:8] <= dq_i[15:8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            open_q  <= '0;
            for (int i = 0; i < NB; i++) row_q[i] <= '0;
            cl_q    <= 2'(RST_CL);
            bl_q    <= 2'd0;
            sw_q    <= 1'b0;
            mset_q  <= 1'b0;
            bact_q  <= 1'b0;
            bwr_q   <= 1'b0;
            bba_q   <= '0;
            brow_q  <= '0;
            bcol_q  <= '0;
            bk_q    <= 3'd0;
            bcode_q <= 2'd0;
            p1_v_q  <= 1'b0;
            p1_oe_q <= 1'b0;
            p1_a_q  <= '0;
            p2_v_q  <= 1'b0;
            p2_oe_q <= 1'b0;
            p2_a_q  <= '0;
            dq_o_q  <= 16'h0000;
            dq_oe_q <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 3'd0;
        end else begin
            open_q  <= open_d;
            row_q   <= row_d;
            cl_q    <= cl_d;
            bl_q    <= bl_d;
            sw_q    <= sw_d;
            mset_q  <= mset_d;
            bact_q  <= bact_d;
            bwr_q   <= bwr_d;
            bba_q   <= bba_d;
            brow_q  <= brow_d;
            bcol_q  <= bcol_d;
            bk_q    <= bk_d;
            bcode_q <= bcode_d;
            p1_v_q  <= p1_v_d;
            p1_oe_q <= p1_oe_d;
            p1_a_q  <= p1_a_d;
            p2_v_q  <= p2_v_d;
            p2_oe_q <= p2_oe_d;
            p2_a_q  <= p2_a_d;
            dq_o_q  <= dq_o_d;
            dq_oe_q <= dq_oe_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign dq_o     = dq_o_q;
    assign dq_oe    = dq_oe_q;
    assign err      = err_q;
    assign err_code = code_q;
endmodule

// File: tb/tb_sdr_sdram_16_resp.sv
// Directed bench for sdr_sdram_16_resp: write/read bursts, DQM, interruption, errors.
module tb_sdr_sdram_16_resp;
    localparam logic [2:0] NOP = 3'b111;
    localparam logic [2:0] ACT = 3'b011;
    localparam logic [2:0] RD  = 3'b101;
    localparam logic [2:0] WR  = 3'b100;
    localparam logic [2:0] PCH = 3'b010;
    localparam logic [2:0] LMR = 3'b000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  ba = 2'd0;
    logic [12:0] a = 13'd0;
    logic [2:0]  cmd = NOP;
    logic [1:0]  dqm = 2'd0;
    logic [15:0] dq_i = 16'd0;
    logic [15:0] dq_o;
    logic        dq_oe;
    logic        err;
    logic [2:0]  err_code;

    int          checks = 0;
    int          errors = 0;
    int          ecnt = 0;
    logic [16:0] olog [0:1023];

    sdr_sdram_16_resp dut (
        .clk      (clk),
        .rst      (rst),
        .ba       (ba),
        .a        (a),
        .cmd      (cmd),
        .dqm      (dqm),
        .dq_i     (dq_i),
        .dq_o     (dq_o),
        .dq_oe    (dq_oe),
        .err      (err),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    // olog[n] holds {dq_oe, dq_o} as updated by edge n.
    always @(posedge clk) begin
        ecnt++;
        #1 olog[ecnt] = {dq_oe, dq_o};
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [2:0] c, input logic [1:0] b,
                        input logic [12:0] ad, input logic [1:0] m,
                        input logic [15:0] d, output int e);
        cmd  = c;
        ba   = b;
        a    = ad;
        dqm  = m;
        dq_i = d;
        @(posedge clk);
        @(negedge clk);
        e = ecnt;
    endtask

    task automatic nop(input int n);
        int d;
        repeat (n) step(NOP, 2'd0, 13'd0, 2'b00, 16'h0000, d);
    endtask

    initial begin
        int e;
        int r;
        logic [15:0] t4 [6];
        t4[0] = 16'h0001; t4[1] = 16'h0002; t4[2] = 16'h0003;
        t4[3] = 16'h0004; t4[4] = 16'h0001; t4[5] = 16'h0002;

        repeat (2) @(negedge clk);
        chk("rst_oe", 32'(dq_oe), 32'd0);
        chk("rst_dq", 32'(dq_o), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_code", 32'(err_code), 32'd0);
        rst = 1'b0;
        nop(1);

        // CL2 BL2 write then read
        step(LMR, 2'd0, 13'h021, 2'b00, 16'h0000, e);
        step(ACT, 2'd1, 13'd3, 2'b00, 16'h0000, e);
        nop(1);
        step(WR, 2'd1, 13'd4, 2'b00, 16'h1234, e);
        step(NOP, 2'd0, 13'd0, 2'b00, 16'hABCD, e);
        step(RD, 2'd1, 13'd4, 2'b00, 16'h0000, r);
        nop(4);
        chk("t1_pre", 32'(olog[r][16]), 32'd0);
        chk("t1_b0", 32'(olog[r+1]), 32'h1_1234);
        chk("t1_b1", 32'(olog[r+2]), 32'h1_ABCD);
        chk("t1_post", 32'(olog[r+3][16]), 32'd0);
        chk("t1_err", 32'(err), 32'd0);

        // CL3 BL4 wrapped read
        step(PCH, 2'd0, 13'h400, 2'b00, 16'h0000, e);
        nop(1);
        step(LMR, 2'd0, 13'h032, 2'b00, 16'h0000, e);
        step(ACT, 2'd1, 13'd3, 2'b00, 16'h0000, e);
        nop(1);
        step(WR, 2'd1, 13'd4, 2'b00, 16'h0001, e);
        step(NOP, 2'd0, 13'd0, 2'b00, 16'h0002, e);
        step(NOP, 2'd0, 13'd0, 2'b00, 16'h0003, e);
        step(NOP, 2'd0, 13'd0, 2'b00, 16'h0004, e);
        step(RD, 2'd1, 13'd6, 2'b00, 16'h0000, r);
        nop(7);
        chk("t2_pre", 32'(olog[r+1][16]), 32'd0);
        chk("t2_b0", 32'(olog[r+2]), 32'h1_0003);
        chk("t2_b1", 32'(olog[r+3]), 32'h1_0004);
        chk("t2_b2", 32'(olog[r+4]), 32'h1_0001);
        chk("t2_b3", 32'(olog[r+5]), 32'h1_0002);
        chk("t2_post", 32'(olog[r+6][16]), 32'd0);

        // byte masks on write and read
        step(ACT, 2'd2, 13'd5, 2'b00, 16'h0000, e);
        nop(1);
        step(WR, 2'd2, 13'd0, 2'b00, 16'h0000, e);
        nop(3);
        step(WR, 2'd2, 13'd0, 2'b10, 16'hFFFF, e);
        step(NOP, 2'd0, 13'd0, 2'b01, 16'hFFFF, e);
        step(NOP, 2'd0, 13'd0, 2'b11, 16'hFFFF, e);
        step(NOP, 2'd0, 13'd0, 2'b11, 16'hFFFF, e);
        step(RD, 2'd2, 13'd0, 2'b00, 16'h0000, r);
        step(NOP, 2'd0, 13'd0, 2'b11, 16'h0000, e);
        nop(6);
        chk("t3_b0", 32'(olog[r+2]), 32'h1_00FF);
        chk("t3_b1_oe", 32'(olog[r+3][16]), 32'd0);
        chk("t3_b2", 32'(olog[r+4]), 32'h1_0000);
        chk("t3_b3", 32'(olog[r+5]), 32'h1_0000);

        // read interrupted by read two cycles later
        step(RD, 2'd1, 13'd4, 2'b00, 16'h0000, r);
        nop(1);
        step(RD, 2'd1, 13'd6, 2'b00, 16'h0000, e);
        nop(8);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t4_b%0d", i), 32'(olog[r+2+i]), {15'd0, 1'b1, t4[i]});
        end
        chk("t4_post", 32'(olog[r+8][16]), 32'd0);
        chk("t4_err", 32'(err), 32'd0);

        // RD one cycle after ACT
        step(ACT, 2'd3, 13'd1, 2'b00, 16'h0000, e);
        nop(1);
        step(WR, 2'd3, 13'd0, 2'b00, 16'h5A5A, e);
        step(NOP, 2'd0, 13'd0, 2'b00, 16'h5A5A, e);
        step(NOP, 2'd0, 13'd0, 2'b00, 16'h5A5A, e);
        step(NOP, 2'd0, 13'd0, 2'b00, 16'h5A5A, e);
        step(PCH, 2'd3, 13'd0, 2'b00, 16'h0000, e);
        nop(2);
        chk("t5_clean", 32'(err), 32'd0);
        step(ACT, 2'd3, 13'd1, 2'b00, 16'h0000, e);
        step(RD, 2'd3, 13'd0, 2'b00, 16'h0000, r);
        nop(5);
        chk("t5_data", 32'(olog[r+2]), 32'h1_5A5A);
`ifdef SDR_RESP_TIMING_CHK_EN
        chk("t5_err", 32'(err), 32'd1);
        chk("t5_code", 32'(err_code), 32'd7);
`else
        chk("t5_err", 32'(err), 32'd0);
        chk("t5_code", 32'(err_code), 32'd0);
`endif

        // asynchronous reset in the middle of a read burst
        step(RD, 2'd1, 13'd4, 2'b00, 16'h0000, r);
        nop(2);
        chk("mid_oe", 32'(dq_oe), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_oe", 32'(dq_oe), 32'd0);
        chk("arst_dq", 32'(dq_o), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // RD to closed bank before LMR: codes 3 and 4 together, 3 wins
        step(ACT, 2'd0, 13'd0, 2'b00, 16'h0000, e);
        nop(2);
        step(RD, 2'd2, 13'd0, 2'b00, 16'h0000, r);
        nop(1);
        chk("t6_err", 32'(err), 32'd1);
        chk("t6_code", 32'(err_code), 32'd3);
        step(ACT, 2'd0, 13'd0, 2'b00, 16'h0000, e);
        nop(3);
        chk("t6_sticky", 32'(err_code), 32'd3);
        chk("t6_oe", 32'(olog[r][16] | olog[r+1][16] | olog[r+2][16]
                        | olog[r+3][16] | olog[r+4][16]), 32'd0);

        // write while responder drives dq
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step(LMR, 2'd0, 13'h021, 2'b00, 16'h0000, e);
        step(ACT, 2'd0, 13'd0, 2'b00, 16'h0000, e);
        nop(1);
        step(RD, 2'd0, 13'd0, 2'b00, 16'h0000, r);
        nop(1);
        chk("t7_clean", 32'(err), 32'd0);
        step(WR, 2'd0, 13'd0, 2'b00, 16'h0000, e);
        nop(2);
        chk("t7_code", 32'(err_code), 32'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
